// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset supervisor.
package pll_reset_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    if (value == {COUNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync_bit.sv
// Multi-flop level synchroniser with asynchronous active-high clear to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset supervisor: sequences the PLL reset, qualifies lock stability and
// releases system reset, retrying on lock timeout or lock loss.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] lock_loss_count,
  output logic [COUNT_W-1:0] retry_count
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  pll_state_t       r_state;
  pll_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_locked_s;
  logic             w_pll_rst_d;
  logic             w_sys_rst_d;
  logic             w_retry_inc;
  logic             w_loss_inc;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .i_clk(clk),
    .i_rst(rst),
    .i_d  (pll_locked),
    .o_q  (w_locked_s)
  );

  // State register and dwell counter, cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PLL_RESET;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state decision; lock beats timeout in WAIT_LOCK.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      PLL_RESET: begin
        if (r_cnt == RST_LAST) begin
          w_next_state = WAIT_LOCK;
        end else begin
          w_next_state = PLL_RESET;
        end
      end
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_next_state = STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next_state = PLL_RESET;
        end else begin
          w_next_state = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!w_locked_s) begin
          w_next_state = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_next_state = RUN;
        end else begin
          w_next_state = STABLE;
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_next_state = PLL_RESET;
        end else begin
          w_next_state = RUN;
        end
      end
      default: w_next_state = PLL_RESET;
    endcase
  end

  // Output decode from the next state so registered outputs move with state.
  always_comb begin
    w_pll_rst_d = (w_next_state == PLL_RESET);
    w_sys_rst_d = (w_next_state != RUN);
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      WAIT_LOCK: w_retry_inc = !w_locked_s && (r_cnt == TIMEOUT_LAST);
      RUN:       w_loss_inc  = !w_locked_s;
      default: begin
        w_retry_inc = 1'b0;
        w_loss_inc  = 1'b0;
      end
    endcase
  end

  // Registered reset outputs and saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      retry_count     <= {COUNT_W{1'b0}};
      lock_loss_count <= {COUNT_W{1'b0}};
    end else begin
      pll_rst <= w_pll_rst_d;
      sys_rst <= w_sys_rst_d;
      if (w_retry_inc) begin
        retry_count <= sat_inc(retry_count);
      end
      if (w_loss_inc) begin
        lock_loss_count <= sat_inc(lock_loss_count);
      end
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed self-checking bench for pll_reset_ctrl with short cycle parameters.
module tb_pll_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic [1:0] state;
  logic [7:0] lock_loss_count;
  logic [7:0] retry_count;

  int checks   = 0;
  int failures = 0;

  pll_reset_ctrl #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .state          (state),
    .lock_loss_count(lock_loss_count),
    .retry_count    (retry_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    tick();
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%0b exp=1", pll_rst); end
    checks++; if (sys_rst !== 1'b1) begin failures++; $display("FAIL reset_sys_rst got=%0b exp=1", sys_rst); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (retry_count !== 8'd0) begin failures++; $display("FAIL reset_retry got=%0d exp=0", retry_count); end
    checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("FAIL reset_loss got=%0d exp=0", lock_loss_count); end
  endtask

  task automatic test_release;
    logic       exp_rst;
    logic [1:0] exp_state;
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      exp_rst   = (e < 4);
      exp_state = (e < 4) ? 2'd0 : 2'd1;
      checks++; if (pll_rst !== exp_rst) begin failures++; $display("FAIL release_pll_rst edge=%0d got=%0b exp=%0b", e, pll_rst, exp_rst); end
      checks++; if (state !== exp_state) begin failures++; $display("FAIL release_state edge=%0d got=%0d exp=%0d", e, state, exp_state); end
      checks++; if (sys_rst !== 1'b1) begin failures++; $display("FAIL release_sys_rst edge=%0d got=%0b exp=1", e, sys_rst); end
    end
  endtask

  task automatic test_lock;
    logic exp_sys;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL lock_pre_state got=%0d exp=1", state); end
    pll_locked = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      exp_sys = (e < 11);
      checks++; if (sys_rst !== exp_sys) begin failures++; $display("FAIL lock_sys_rst edge=%0d got=%0b exp=%0b", e, sys_rst, exp_sys); end
      if (e == 3) begin
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL lock_stable_state got=%0d exp=2", state); end
      end
    end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL lock_run_state got=%0d exp=3", state); end
    checks++; if (retry_count !== 8'd0) begin failures++; $display("FAIL lock_retry got=%0d exp=0", retry_count); end
    checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("FAIL lock_loss got=%0d exp=0", lock_loss_count); end
  endtask

  task automatic test_lock_loss;
    logic exp_hi;
    int   n;
    pll_locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      exp_hi = (e >= 3);
      checks++; if (sys_rst !== exp_hi) begin failures++; $display("FAIL loss_sys_rst edge=%0d got=%0b exp=%0b", e, sys_rst, exp_hi); end
      checks++; if (pll_rst !== exp_hi) begin failures++; $display("FAIL loss_pll_rst edge=%0d got=%0b exp=%0b", e, pll_rst, exp_hi); end
    end
    checks++; if (lock_loss_count !== 8'd1) begin failures++; $display("FAIL loss_count got=%0d exp=1", lock_loss_count); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL loss_state got=%0d exp=0", state); end
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 13) begin failures++; $display("FAIL reseq_edges got=%0d exp=13", n); end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL reseq_state got=%0d exp=3", state); end
  endtask

  task automatic test_async_reset;
    checks++; if (sys_rst !== 1'b0) begin failures++; $display("FAIL arst_pre_sys_rst got=%0b exp=0", sys_rst); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sys_rst !== 1'b1) begin failures++; $display("FAIL arst_sys_rst got=%0b exp=1", sys_rst); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL arst_pll_rst got=%0b exp=1", pll_rst); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL arst_state got=%0d exp=0", state); end
    checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("FAIL arst_loss got=%0d exp=0", lock_loss_count); end
    checks++; if (retry_count !== 8'd0) begin failures++; $display("FAIL arst_retry got=%0d exp=0", retry_count); end
    tick();
  endtask

  task automatic test_stable_glitch;
    logic exp_sys;
    pll_locked = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      tick();
      exp_sys = (e < 22);
      checks++; if (sys_rst !== exp_sys) begin failures++; $display("FAIL glitch_sys_rst edge=%0d got=%0b exp=%0b", e, sys_rst, exp_sys); end
      if (e == 5 || e == 11 || e == 14) begin
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL glitch_stable edge=%0d got=%0d exp=2", e, state); end
      end
      if (e == 12 || e == 13) begin
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL glitch_wait edge=%0d got=%0d exp=1", e, state); end
      end
      if (e == 22) begin
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL glitch_run edge=%0d got=%0d exp=3", e, state); end
      end
      if (e == 9) pll_locked = 1'b0;
      if (e == 11) pll_locked = 1'b1;
    end
  endtask

  task automatic test_timeout_vs_lock;
    pll_locked = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 36; e++) begin
      tick();
      if (e == 35) begin
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL tie_pre_state got=%0d exp=1", state); end
      end
      if (e == 36) begin
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL tie_state got=%0d exp=2", state); end
        checks++; if (retry_count !== 8'd0) begin failures++; $display("FAIL tie_retry got=%0d exp=0", retry_count); end
        checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL tie_pll_rst got=%0b exp=0", pll_rst); end
      end
      if (e == 33) pll_locked = 1'b1;
    end
  endtask

  task automatic test_timeout;
    logic exp_rst;
    pll_locked = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 10800; e++) begin
      tick();
      if (e <= 40) begin
        exp_rst = (e < 4) || (e >= 36 && e < 40);
        checks++; if (pll_rst !== exp_rst) begin failures++; $display("FAIL timeout_pll_rst edge=%0d got=%0b exp=%0b", e, pll_rst, exp_rst); end
      end
      if (e == 35) begin
        checks++; if (retry_count !== 8'd0) begin failures++; $display("FAIL timeout_retry0 got=%0d exp=0", retry_count); end
      end
      if (e == 36) begin
        checks++; if (retry_count !== 8'd1) begin failures++; $display("FAIL timeout_retry1 got=%0d exp=1", retry_count); end
        checks++; if (sys_rst !== 1'b1) begin failures++; $display("FAIL timeout_sys_rst got=%0b exp=1", sys_rst); end
      end
      if (e == 36 * 254 + 35) begin
        checks++; if (retry_count !== 8'd254) begin failures++; $display("FAIL timeout_retry254 got=%0d exp=254", retry_count); end
      end
      if (e == 36 * 255) begin
        checks++; if (retry_count !== 8'd255) begin failures++; $display("FAIL timeout_retry255 got=%0d exp=255", retry_count); end
      end
      if (e == 10800) begin
        checks++; if (retry_count !== 8'd255) begin failures++; $display("FAIL timeout_saturate got=%0d exp=255", retry_count); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL timeout_state got=%0d exp=0", state); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL timeout_final_pll_rst got=%0b exp=1", pll_rst); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_release();
    test_lock();
    test_lock_loss();
    test_async_reset();
    test_stable_glitch();
    test_timeout_vs_lock();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
